pencoder_serial: RTL and testbench

- Parametrised, sequential successor to the 8-to-3 priority encoder.
- Captures an N-bit multi-hot request vector into a pending register.
- Emits the index of every set bit, one per handshake, highest index first, over a valid/ready output interface.
- Sits between request sources (interrupt lines, channel flags) and a single-index consumer, so no simultaneous request is lost.

---
 rtl/pencoder_pkg.sv | 22 ++
 rtl/penc_msb_index.sv | 26 ++
 rtl/pencoder_serial.sv | 101 ++++++++++
 tb/tb_pencoder_serial.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pencoder_pkg.sv
// Shared types and helpers for the serial priority encoder.
package pencoder_pkg;

   // Largest request width the bit-count helper accepts.
   localparam int MAX_N = 1024;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Width of an index that can address n request lines.
   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

   // True when exactly one bit of v is set.
   function automatic logic onehot_count_is_one(input logic [MAX_N-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/penc_msb_index.sv
// Combinational highest-set-bit encoder: index of the top set bit of req,
// plus a found flag. idx is 0 when no bit is set.
module penc_msb_index
   import pencoder_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pencoder_serial.sv
// Serial priority encoder: captures a multi-hot request vector and emits
// the index of every set bit, highest first, over a valid/ready interface.
// Optional macro PENC_MERGE_EN: accept new captures while draining and OR
// them into the pending set (a re-requested retiring bit stays pending).
module pencoder_serial
   import pencoder_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          En,
   input  logic [N-1:0]  d,
   output logic          in_ready,
   output logic [IW-1:0] b,
   output logic          valid,
   input  logic          ready,
   output logic          last,
   output logic          zero
);

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  pend;
   logic [N-1:0]  pend_next;
   logic [N-1:0]  retire;
   logic [IW-1:0] top_idx;
   logic          top_found;
   logic          capture;

   penc_msb_index #(.N(N), .IW(IW)) u_msb (
      .req   (pend),
      .idx   (top_idx),
      .found (top_found)
   );

   assign capture = En && in_ready;

   // One-hot mask of the pending bit handed to the consumer this cycle.
   always_comb begin
      retire = '0;
      for (int i = 0; i < N; i++) begin
         if (valid && ready && top_found && (top_idx == IW'(i))) begin
            retire[i] = 1'b1;
         end
      end
   end

   // Next pending set: retire first, then OR in a capture so a fresh
   // request for the retiring bit keeps it pending.
   always_comb begin
      pend_next = pend & ~retire;
      if (capture) begin
         pend_next = pend_next | d;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: drain as long as anything remains pending.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pend_next != '0) state_next = DRAIN;
         DRAIN:   if (pend_next == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pending-set register and the empty-capture pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
         zero <= 1'b0;
      end else begin
         pend <= pend_next;
         zero <= capture && (d == '0);
      end
   end

   // Registered-only outputs.
   always_comb begin
      valid = (state == DRAIN);
`ifdef PENC_MERGE_EN
      in_ready = 1'b1;
`else
      in_ready = (state == IDLE);
`endif
      b    = valid ? top_idx : '0;
      last = valid && onehot_count_is_one(MAX_N'(pend));
   end

endmodule

// File: tb/tb_pencoder_serial.sv
// Self-checking bench for pencoder_serial: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_pencoder_serial;

   localparam int N  = 8;
   localparam int IW = 3;
`ifdef PENC_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          En;
   logic [N-1:0]  d;
   logic          in_ready;
   logic [IW-1:0] b;
   logic          valid;
   logic          ready;
   logic          last;
   logic          zero;

   int checks = 0;
   int errors = 0;

   pencoder_serial #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .En       (En),
      .d        (d),
      .in_ready (in_ready),
      .b        (b),
      .valid    (valid),
      .ready    (ready),
      .last     (last),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of indices still to be emitted, highest first.
   int   q[$];
   logic mzero = 1'b0;
   bit   mlive = 1'b0;

   always @(posedge clk) begin
      bit           can_cap;
      logic [N-1:0] bits;
      if (rst) begin
         q.delete();
         mzero = 1'b0;
         mlive = 1'b1;
      end else if (mlive) begin
         can_cap = MERGE ? 1'b1 : (q.size() == 0);
         if (q.size() > 0 && ready) void'(q.pop_front());
         mzero = En && can_cap && (d == '0);
         if (En && can_cap && d != '0) begin
            bits = '0;
            foreach (q[i]) bits[q[i]] = 1'b1;
            bits = bits | d;
            q.delete();
            for (int i = N - 1; i >= 0; i--) if (bits[i]) q.push_back(i);
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (mlive) begin
         chk("valid", 32'(valid), 32'(q.size() > 0));
         chk("b", 32'(b), (q.size() > 0) ? 32'(q[0]) : 32'd0);
         chk("last", 32'(last), 32'(q.size() == 1));
         chk("in_ready", 32'(in_ready), MERGE ? 32'd1 : 32'(q.size() == 0));
         chk("zero", 32'(zero), 32'(mzero));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; En = 1'b1; d = 8'hFF; ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_b", 32'(b), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_zero", 32'(zero), 32'd0);
      rst = 1'b0; En = 1'b0; d = '0;

      // Multi-hot drain of A4 -> 7, 5, 2.
      @(negedge clk);
      En = 1'b1; d = 8'hA4; ready = 1'b1;
      @(negedge clk); En = 1'b0;
      chk("a4_b0", 32'(b), 32'd7);
      chk("a4_last0", 32'(last), 32'd0);
      @(negedge clk);
      chk("a4_b1", 32'(b), 32'd5);
      @(negedge clk);
      chk("a4_b2", 32'(b), 32'd2);
      chk("a4_last2", 32'(last), 32'd1);
      @(negedge clk);
      chk("a4_idle", 32'(in_ready), 32'd1);
      chk("a4_novalid", 32'(valid), 32'd0);

      // Backpressure on 81.
      En = 1'b1; d = 8'h81; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); En = 1'b0;
         chk("bp_valid", 32'(valid), 32'd1);
         chk("bp_b", 32'(b), 32'd7);
      end
      ready = 1'b1;
      @(negedge clk);
      chk("bp_b_last", 32'(b), 32'd0);
      chk("bp_last", 32'(last), 32'd1);
      @(negedge clk);
      chk("bp_idle", 32'(valid), 32'd0);

      // Empty capture.
      ready = 1'b0; En = 1'b1; d = 8'h00;
      @(negedge clk); En = 1'b0;
      chk("zero_pulse", 32'(zero), 32'd1);
      chk("zero_novalid", 32'(valid), 32'd0);
      @(negedge clk);
      chk("zero_end", 32'(zero), 32'd0);

      // Reset mid-drain.
      En = 1'b1; d = 8'hF0; ready = 1'b1;
      @(negedge clk); En = 1'b0;
      chk("mr_b0", 32'(b), 32'd7);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_flush", 32'(valid), 32'd0);
      rst = 1'b0; En = 1'b1; d = 8'h01;
      @(negedge clk); En = 1'b0;
      chk("mr_b", 32'(b), 32'd0);
      chk("mr_last", 32'(last), 32'd1);
      @(negedge clk);
      chk("mr_done", 32'(valid), 32'd0);

`ifdef PENC_MERGE_EN
      // Merge while retiring the last bit.
      En = 1'b1; d = 8'h10; ready = 1'b1;
      @(negedge clk);
      chk("mg_b0", 32'(b), 32'd4);
      d = 8'h12;
      @(negedge clk); En = 1'b0;
      chk("mg_valid", 32'(valid), 32'd1);
      chk("mg_b1", 32'(b), 32'd4);
      @(negedge clk);
      chk("mg_b2", 32'(b), 32'd1);
      chk("mg_last", 32'(last), 32'd1);
      @(negedge clk);
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(199) == 0);
         En    = ($urandom_range(2) == 0);
         d     = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         ready = ($urandom_range(3) != 0);
         @(negedge clk);
      end
      rst = 1'b0; En = 1'b0; ready = 1'b1;
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
